// File: rtl/mcu_video_cfg_ctrl.sv
// MCU frame parser for the video path: forwards OSD bytes, decodes configuration writes
// into shadow registers and answers status reads. Shadow settings reach the datapath only
// on a locked vsync falling edge, so a change never lands mid-frame.
module mcu_video_cfg_ctrl #(
  parameter logic [7:0] CMD_OSD    = 8'h01,
  parameter logic [7:0] CMD_CFG    = 8'h02,
  parameter logic [7:0] CMD_STATUS = 8'h03,
  parameter logic [1:0] VOL_RESET  = 2'd3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       mcu_start,
  input  logic       mcu_strobe,
  input  logic [7:0] mcu_data,
  output logic [7:0] mcu_rdata,
  input  logic       vs_n,
  input  logic       pll_lock,
  output logic       osd_start,
  output logic       osd_strobe,
  output logic [7:0] osd_data,
  output logic [1:0] system_scanlines,
  output logic [1:0] system_volume,
  output logic       system_wide_screen,
  output logic       cfg_pending,
  output logic [3:0] err_cnt
);

  typedef enum logic [2:0] {
    StIdle, StOsdFwd, StCfgAddr, StCfgData, StStatus, StIgnore
  } state_t;

  state_t      r_state;
  logic [7:0]  r_addr;
  logic [7:0]  r_rdata;
  logic        r_osd_start;
  logic        r_osd_strobe;
  logic [7:0]  r_osd_data;
  logic [3:0]  r_err;
  logic [1:0]  r_scan_s, r_vol_s;
  logic        r_wide_s;
  logic [1:0]  r_scan_c, r_vol_c;
  logic        r_wide_c;
  logic        r_pending;
  logic        r_vs_prev;

  logic        w_cmd_known;
  logic [1:0]  w_err_inc;
  logic [4:0]  w_err_sum;
  logic [3:0]  w_err_next;
  logic        w_vs_fall;
  logic [7:0]  w_status;

  assign w_cmd_known = (mcu_data == CMD_OSD) || (mcu_data == CMD_CFG) ||
                       (mcu_data == CMD_STATUS);
  assign w_vs_fall   = r_vs_prev & ~vs_n;
  assign w_status    = {pll_lock, r_pending, r_wide_c, r_vol_c, r_scan_c, 1'b0};

  // Error increments: an aborted CFG frame and an unknown command can coincide (+2).
  always_comb begin
    w_err_inc = 2'd0;
    if (mcu_strobe) begin
      if (mcu_start) begin
        if ((r_state == StCfgAddr) || (r_state == StCfgData)) w_err_inc = w_err_inc + 2'd1;
        if (!w_cmd_known) w_err_inc = w_err_inc + 2'd1;
      end else if ((r_state == StCfgData) && (r_addr > 8'd2)) begin
        w_err_inc = 2'd1;
      end
    end
    w_err_sum  = {1'b0, r_err} + {3'b000, w_err_inc};
    w_err_next = (w_err_sum > 5'd15) ? 4'hF : w_err_sum[3:0];
  end

  // Frame parser FSM with registered OSD/readback outputs and shadow register writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_addr       <= 8'h00;
      r_rdata      <= 8'h00;
      r_osd_start  <= 1'b0;
      r_osd_strobe <= 1'b0;
      r_osd_data   <= 8'h00;
      r_err        <= 4'h0;
      r_scan_s     <= 2'd0;
      r_vol_s      <= VOL_RESET;
      r_wide_s     <= 1'b0;
    end else begin
      r_osd_start  <= 1'b0;
      r_osd_strobe <= 1'b0;
      r_err        <= w_err_next;
      if (mcu_strobe) begin
        r_rdata <= 8'h00;
        if (mcu_start) begin
          if (mcu_data == CMD_OSD) begin
            r_state      <= StOsdFwd;
            r_osd_start  <= 1'b1;
            r_osd_strobe <= 1'b1;
            r_osd_data   <= mcu_data;
          end else if (mcu_data == CMD_CFG) begin
            r_state <= StCfgAddr;
          end else if (mcu_data == CMD_STATUS) begin
            r_state <= StStatus;
            r_rdata <= w_status;
          end else begin
            r_state <= StIgnore;
          end
        end else begin
          unique case (r_state)
            StOsdFwd: begin
              r_osd_strobe <= 1'b1;
              r_osd_data   <= mcu_data;
            end
            StCfgAddr: begin
              r_addr  <= mcu_data;
              r_state <= StCfgData;
            end
            StCfgData: begin
              case (r_addr)
                8'd0:    r_scan_s <= mcu_data[1:0];
                8'd1:    r_vol_s  <= mcu_data[1:0];
                8'd2:    r_wide_s <= mcu_data[0];
                default: ;
              endcase
              r_state <= StIgnore;
            end
            StStatus: begin
              r_rdata <= {4'h0, r_err};
              r_state <= StIgnore;
            end
            StIdle, StIgnore: ;
            default: r_state <= StIdle;
          endcase
        end
      end
    end
  end

  // Vsync edge detect and commit; commit sees pre-write shadow if a write lands the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vs_prev <= 1'b1;
      r_pending <= 1'b0;
      r_scan_c  <= 2'd0;
      r_vol_c   <= VOL_RESET;
      r_wide_c  <= 1'b0;
    end else begin
      r_vs_prev <= vs_n;
      r_pending <= (r_scan_s != r_scan_c) || (r_vol_s != r_vol_c) || (r_wide_s != r_wide_c);
      if (w_vs_fall && pll_lock) begin
        r_scan_c <= r_scan_s;
        r_vol_c  <= r_vol_s;
        r_wide_c <= r_wide_s;
      end
    end
  end

  assign mcu_rdata          = r_rdata;
  assign osd_start          = r_osd_start;
  assign osd_strobe         = r_osd_strobe;
  assign osd_data           = r_osd_data;
  assign system_scanlines   = r_scan_c;
  assign system_volume      = r_vol_c;
  assign system_wide_screen = r_wide_c;
  assign cfg_pending        = r_pending;
  assign err_cnt            = r_err;

endmodule

// File: doc/mcu_video_cfg_ctrl.md
Name: mcu_video_cfg_ctrl

Overview:
- Sits between the MCU SPI byte interface and the video/HDMI datapath.
- Parses framed MCU byte streams and does one of three things per frame:
  - forwards OSD payloads to the OSD renderer;
  - decodes configuration writes into shadow registers;
  - returns a status byte.
- Shadow settings (scanlines, volume, wide screen) are committed to the datapath only on the falling edge of vsync, so a settings change never causes mid-frame tearing or audio steps.

Parameters:
- CMD_OSD, 8'h01, command byte selecting OSD forwarding
- CMD_CFG, 8'h02, command byte selecting configuration write
- CMD_STATUS, 8'h03, command byte selecting status read
- VOL_RESET, 2'd3, reset value of system_volume

Ports:
- clk  input  1  system clock (32 MHz video domain)
- resetn  input  1  asynchronous active-low reset
- mcu_start  input  1  frame start; high for one strobe with the command byte
- mcu_strobe  input  1  one-cycle pulse, mcu_data valid
- mcu_data  input  8  MCU byte
- mcu_rdata  output  8  byte returned to MCU; valid the cycle after a strobe
- vs_n  input  1  active-low vsync (already in clk domain)
- pll_lock  input  1  HDMI PLL lock
- osd_start  output  1  forwarded start to OSD
- osd_strobe  output  1  forwarded strobe to OSD
- osd_data  output  8  forwarded data to OSD
- system_scanlines  output  2  committed scanline mode
- system_volume  output  2  committed volume
- system_wide_screen  output  1  committed wide-screen flag
- cfg_pending  output  1  shadow differs from committed, awaiting vsync
- err_cnt  output  4  saturating count of malformed or unknown frames

Behaviour:
Reset (resetn low, async):
- state = IDLE; all osd_* outputs = 0; mcu_rdata = 0.
- Shadow and committed values: scanlines = 0, volume = VOL_RESET, wide = 0.
- cfg_pending = 0, err_cnt = 0. Reset mid-frame discards the frame.

Strobe qualification:
- Bytes are only acted on when mcu_strobe = 1.
- A strobe with mcu_start = 1 always restarts parsing from CMD decode, regardless of the current state. It aborts the running frame; an aborted CFG frame increments err_cnt.
- Any previously forwarded OSD frame ends with no extra action.

FSM (state advances on qualified strobes only):
- IDLE:
  - start + CMD_OSD: go to OSD_FWD and emit osd_start = 1, osd_strobe = 1, osd_data = command byte, all in the next cycle (1-cycle latency, single pulse).
  - start + CMD_CFG: go to CFG_ADDR.
  - start + CMD_STATUS: go to STATUS.
  - start + other command: go to IGNORE and increment err_cnt.
  - strobe without start: ignored.
- OSD_FWD: each strobe produces osd_strobe = 1 and osd_data = mcu_data one cycle later, with osd_start = 0. The state persists until the next start.
- CFG_ADDR: latch the address byte and go to CFG_DATA.
- CFG_DATA: write the shadow register, then go to IGNORE.
  - Address 0: scanlines = data[1:0].
  - Address 1: volume = data[1:0].
  - Address 2: wide = data[0].
  - Any other address: no write, increment err_cnt.
- STATUS: on the command strobe, mcu_rdata = {pll_lock, cfg_pending, wide, volume, scanlines, 1'b0}. The following strobes return err_cnt zero-extended to 8 bits, then stay in IGNORE.
- IGNORE: swallow bytes until the next start.

Outside STATUS, mcu_rdata = 8'h00 (updated on each strobe). osd_strobe and osd_start are never high for more than one cycle.

Commit:
- The controller registers vs_n once. A falling edge is prev = 1, cur = 0.
- On the falling-edge cycle, committed registers take the shadow values when pll_lock = 1. If pll_lock = 0, the commit is deferred to the next edge with lock.
- cfg_pending = (shadow != committed), registered, so it updates one cycle after the change.
- Simultaneous CFG_DATA write and vsync edge in the same cycle: the commit uses the old shadow. The new value commits on the following vsync and cfg_pending stays 1.

Counters: err_cnt saturates at 15.

Test Plan:
- Reset, then release -> scanlines = 0, volume = 3, wide = 0, err_cnt = 0, osd_* = 0, mcu_rdata = 0.
- Frame {01 start, AA, 55} -> three single-cycle osd_strobe pulses with data 01, AA, 55, one cycle after each input strobe; osd_start only on the first.
- Frame {02 start, 01, 02}, vs_n high -> system_volume stays 3 and cfg_pending = 1. After a vs_n high->low edge with pll_lock = 1 -> volume = 2 one cycle later and cfg_pending = 0.
- Same write with pll_lock = 0 across two vsync edges -> no commit. Raise lock, next edge -> commit.
- Frame {02 start, 07, 01} -> no shadow change, err_cnt = 1. Frame {09 start} -> err_cnt = 2. Seventeen more bad frames -> err_cnt = 15 (saturates).
- Frame {02 start, 00} aborted by {03 start} -> err_cnt increments, mcu_rdata = status byte with bit 7 = pll_lock; next strobe returns err_cnt.
